// File: rtl/tone_decoder.sv
// tone_decoder: measures the half-period of a square wave and
// locks onto one of 13 doorbell notes once several periods agree.
module tone_decoder #(
  parameter int CNT_W     = 17,
  parameter int LOCK_CNT  = 4,
  parameter int TOL_SHIFT = 6,
  parameter int TIMEOUT   = 100000,
  parameter logic [12:0][31:0] NK = {
    32'd18961, 32'd21283, 32'd23890, 32'd25309,
    32'd28410, 32'd31888, 32'd35791, 32'd37920,
    32'd42568, 32'd47775, 32'd50618, 32'd56819,
    32'd63776}
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             TONE_IN,
  output logic [3:0]       NOTE_IDX,
  output logic             NOTE_VALID,
  output logic             NOTE_STB,
  output logic [CNT_W-1:0] HALF_PERIOD,
  output logic [15:0]      LED
);

  localparam int MC_W = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
  localparam logic [MC_W-1:0] LAST = MC_W'(LOCK_CNT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACQUIRE,
    LOCKED
  } state_t;

  logic             s1_q, s2_q, s3_q;
  logic             edge_d, edge_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] half_q;
  logic             have_ref_q;
  logic             meas_q;
  logic             hit_d, hit_q;
  logic [3:0]       hidx_d, hidx_q;
  logic             tmo;
  logic [31:0]      h32, diff;

  state_t           st_q;
  logic [3:0]       cand_q;
  logic [MC_W-1:0]  mc_q;
  logic [3:0]       idx_q;
  logic             valid_q;
  logic             stb_q;
  logic [15:0]      led_q;

  // Two-stage synchronizer plus one history bit for edge detection;
  // left unreset so a reset pulse never fabricates an edge.
  always_ff @(posedge CLK) begin
    s1_q <= TONE_IN;
    s2_q <= s1_q;
    s3_q <= s2_q;
  end

  assign edge_d = s2_q ^ s3_q;
  assign tmo    = (cnt_q == TMO) && !edge_q;

  // Find the table entry whose tolerance window holds the count.
  always_comb begin
    hit_d  = 1'b0;
    hidx_d = 4'd0;
    diff   = 32'd0;
    h32    = 32'(cnt_q);
    for (int k = 0; k < 13; k++) begin
      diff = (h32 >= NK[k]) ? (h32 - NK[k]) : (NK[k] - h32);
      if (diff <= (NK[k] >> TOL_SHIFT)) begin
        hit_d  = 1'b1;
        hidx_d = 4'(k);
      end
    end
  end

  // Edge-to-edge counter, reference tracking and measurement latch.
  always_ff @(posedge CLK) begin
    if (RST) begin
      edge_q     <= 1'b0;
      cnt_q      <= '0;
      half_q     <= '0;
      have_ref_q <= 1'b0;
      meas_q     <= 1'b0;
      hit_q      <= 1'b0;
      hidx_q     <= 4'd0;
    end else begin
      edge_q <= edge_d;
      meas_q <= edge_q && have_ref_q;
      hit_q  <= hit_d;
      hidx_q <= hidx_d;
      if (edge_q) begin
        cnt_q      <= CNT_W'(1);
        have_ref_q <= 1'b1;
        if (have_ref_q) half_q <= cnt_q;
      end else if (cnt_q != TMO) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else begin
        have_ref_q <= 1'b0;
      end
    end
  end

  // Note lock state machine with registered display outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      st_q    <= IDLE;
      cand_q  <= 4'd0;
      mc_q    <= '0;
      idx_q   <= 4'hF;
      valid_q <= 1'b0;
      stb_q   <= 1'b0;
      led_q   <= 16'd0;
    end else begin
      stb_q <= 1'b0;
      if (meas_q) begin
        unique case (st_q)
          IDLE: begin
            if (hit_q) begin
              st_q   <= ACQUIRE;
              cand_q <= hidx_q;
              mc_q   <= MC_W'(1);
            end
          end
          ACQUIRE: begin
            if (!hit_q) begin
              st_q <= IDLE;
              mc_q <= '0;
            end else if (hidx_q != cand_q) begin
              cand_q <= hidx_q;
              mc_q   <= MC_W'(1);
            end else if (mc_q == LAST) begin
              st_q    <= LOCKED;
              mc_q    <= MC_W'(LOCK_CNT);
              valid_q <= 1'b1;
              idx_q   <= cand_q;
              led_q   <= 16'd1 << cand_q;
              stb_q   <= 1'b1;
            end else begin
              mc_q <= mc_q + MC_W'(1);
            end
          end
          LOCKED: begin
            if (!hit_q) begin
              st_q    <= IDLE;
              mc_q    <= '0;
              valid_q <= 1'b0;
              idx_q   <= 4'hF;
              led_q   <= 16'd0;
            end else if (hidx_q != cand_q) begin
              st_q    <= ACQUIRE;
              cand_q  <= hidx_q;
              mc_q    <= MC_W'(1);
              valid_q <= 1'b0;
              idx_q   <= 4'hF;
              led_q   <= 16'd0;
            end
          end
          default: st_q <= IDLE;
        endcase
      end else if (tmo) begin
        st_q    <= IDLE;
        mc_q    <= '0;
        valid_q <= 1'b0;
        idx_q   <= 4'hF;
        led_q   <= 16'd0;
      end
    end
  end

  assign NOTE_IDX    = idx_q;
  assign NOTE_VALID  = valid_q;
  assign NOTE_STB    = stb_q;
  assign HALF_PERIOD = half_q;
  assign LED         = led_q;

endmodule
